// File: rtl/dmem_store_buffer_if.sv
// Store-buffer bus bundle: store, load-check and RAM write sides.
// slave = the buffer, master = pipeline/RAM side.
interface dmem_store_buffer_if #(
   parameter int DEPTH = 4,
   parameter int AW    = 30,
   parameter int DW    = 32
);
   logic                     st_valid;
   logic [AW-1:0]            st_addr;
   logic [DW-1:0]            st_data;
   logic                     st_ready;
   logic                     ld_valid;
   logic [AW-1:0]            ld_addr;
   logic                     ld_hit;
   logic [DW-1:0]            ld_data;
   logic                     ld_stall;
   logic                     mem_req;
   logic [AW-1:0]            mem_addr;
   logic [DW-1:0]            mem_wdata;
   logic                     mem_ack;
   logic                     empty;
   logic                     full;
   logic [$clog2(DEPTH):0]   count;

   modport slave (
      input  st_valid, st_addr, st_data, ld_valid, ld_addr, mem_ack,
      output st_ready, ld_hit, ld_data, ld_stall,
      output mem_req, mem_addr, mem_wdata, empty, full, count
   );

   modport master (
      output st_valid, st_addr, st_data, ld_valid, ld_addr, mem_ack,
      input  st_ready, ld_hit, ld_data, ld_stall,
      input  mem_req, mem_addr, mem_wdata, empty, full, count
   );
endinterface

// File: rtl/dmem_store_buffer.sv
// Posted-write store buffer with load hazard check.
// STORE_FWD_EN: forward youngest matching store instead of stalling.
module dmem_store_buffer #(
   parameter int DEPTH = 4,
   parameter int AW    = 30,
   parameter int DW    = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   dmem_store_buffer_if.slave   bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [AW-1:0]    addr_q [DEPTH];
   logic [DW-1:0]    data_q [DEPTH];
   logic [DEPTH-1:0] vld_q, vld_d;
   logic [PW-1:0]    head_q, head_d;
   logic [PW-1:0]    tail_q, tail_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             full, empty;
   logic             push, pop;
   logic             match;
   logic [PW-1:0]    idx;
`ifdef STORE_FWD_EN
   logic [DW-1:0]    fwd_data;
`endif

   assign full  = (cnt_q == CW'(DEPTH));
   assign empty = (cnt_q == '0);
   assign push  = bus.st_valid && !full;
   assign pop   = !empty && bus.mem_ack;

   // Next pointers, count and valid bits
   always_comb begin
      vld_d  = vld_q;
      head_d = head_q + PW'(pop);
      tail_d = tail_q + PW'(push);
      cnt_d  = cnt_q + CW'(push) - CW'(pop);
      if (pop)
         vld_d[head_q] = 1'b0;
      if (push)
         vld_d[tail_q] = 1'b1;
   end

   // Control state, cleared asynchronously
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld_q  <= '0;
         head_q <= '0;
         tail_q <= '0;
         cnt_q  <= '0;
      end else begin
         vld_q  <= vld_d;
         head_q <= head_d;
         tail_q <= tail_d;
         cnt_q  <= cnt_d;
      end
   end

   // Entry payload; qualified by valid bits, so no reset
   always_ff @(posedge clk) begin
      if (push) begin
         addr_q[tail_q] <= bus.st_addr;
         data_q[tail_q] <= bus.st_data;
      end
   end

   // Scan head to tail; later matches are younger and win
   always_comb begin
      match = 1'b0;
      idx   = '0;
`ifdef STORE_FWD_EN
      fwd_data = '0;
`endif
      for (int i = 0; i < DEPTH; i++) begin
         idx = head_q + PW'(i);
         if (vld_q[idx] && addr_q[idx] == bus.ld_addr) begin
            match = 1'b1;
`ifdef STORE_FWD_EN
            fwd_data = data_q[idx];
`endif
         end
      end
   end

   assign bus.st_ready  = !full;
   assign bus.mem_req   = !empty;
   assign bus.mem_addr  = empty ? '0 : addr_q[head_q];
   assign bus.mem_wdata = empty ? '0 : data_q[head_q];
   assign bus.empty     = empty;
   assign bus.full      = full;
   assign bus.count     = cnt_q;

`ifdef STORE_FWD_EN
   assign bus.ld_hit   = bus.ld_valid && match;
   assign bus.ld_data  = (bus.ld_valid && match) ? fwd_data : '0;
   assign bus.ld_stall = 1'b0;
`else
   assign bus.ld_hit   = 1'b0;
   assign bus.ld_data  = '0;
   assign bus.ld_stall = bus.ld_valid && match;
`endif
endmodule

// File: tb/tb_dmem_store_buffer.sv
// Directed bench for dmem_store_buffer.
// Expectations follow the STORE_FWD_EN setting of the build.
module tb_dmem_store_buffer;
   logic clk;
   logic rst;
   int   total;
   int   bad;

   dmem_store_buffer_if #(.DEPTH(4), .AW(30), .DW(32)) bus ();

   dmem_store_buffer #(.DEPTH(4), .AW(30), .DW(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs;
      bus.st_valid = 1'b0;
      bus.st_addr  = '0;
      bus.st_data  = '0;
      bus.ld_valid = 1'b0;
      bus.ld_addr  = '0;
      bus.mem_ack  = 1'b0;
   endtask

   task automatic test_reset;
      idle_inputs();
      rst = 1'b0;
      tick();
      tick();
      total++;
      if (bus.mem_req !== 1'b0) begin
         bad++;
         $display("FAIL rst_hold_req got=%0b exp=0", bus.mem_req);
      end
      rst = 1'b1;
      tick();
      total++;
      if (bus.empty !== 1'b1 || bus.st_ready !== 1'b1) begin
         bad++;
         $display("FAIL rst_flags empty=%0b rdy=%0b exp=1,1",
                  bus.empty, bus.st_ready);
      end
      total++;
      if (bus.mem_req !== 1'b0 || bus.count !== 3'd0 || bus.full !== 1'b0) begin
         bad++;
         $display("FAIL rst_state req=%0b cnt=%0d full=%0b exp=0,0,0",
                  bus.mem_req, bus.count, bus.full);
      end
      total++;
      if (bus.mem_addr !== 30'd0 || bus.mem_wdata !== 32'd0 ||
          bus.ld_hit !== 1'b0 || bus.ld_stall !== 1'b0) begin
         bad++;
         $display("FAIL rst_bus addr=%h wd=%h hit=%0b st=%0b exp=0",
                  bus.mem_addr, bus.mem_wdata, bus.ld_hit, bus.ld_stall);
      end
   endtask

   task automatic test_fill;
      bus.mem_ack = 1'b0;
      for (int i = 0; i < 4; i++) begin
         bus.st_valid = 1'b1;
         bus.st_addr  = 30'h10 + 30'(i);
         bus.st_data  = 32'hA0 + 32'(i);
         if (i == 0) begin
            total++;
            if (bus.mem_req !== 1'b0) begin
               bad++;
               $display("FAIL fill_latency got=%0b exp=0", bus.mem_req);
            end
         end
         tick();
         total++;
         if (bus.mem_addr !== 30'h10 || bus.count !== 3'(i + 1)) begin
            bad++;
            $display("FAIL fill_step%0d addr=%h cnt=%0d exp=10,%0d",
                     i, bus.mem_addr, bus.count, i + 1);
         end
      end
      total++;
      if (bus.full !== 1'b1 || bus.st_ready !== 1'b0) begin
         bad++;
         $display("FAIL fill_full full=%0b rdy=%0b exp=1,0",
                  bus.full, bus.st_ready);
      end
      bus.st_addr = 30'h14;
      bus.st_data = 32'hA4;
      tick();
      bus.st_valid = 1'b0;
      total++;
      if (bus.count !== 3'd4 || bus.mem_addr !== 30'h10 ||
          bus.mem_wdata !== 32'hA0) begin
         bad++;
         $display("FAIL fill_drop cnt=%0d addr=%h wd=%h exp=4,10,a0",
                  bus.count, bus.mem_addr, bus.mem_wdata);
      end
   endtask

   task automatic test_drain;
      bus.mem_ack = 1'b1;
      for (int i = 0; i < 4; i++) begin
         total++;
         if (bus.mem_req !== 1'b1 || bus.mem_addr !== 30'h10 + 30'(i) ||
             bus.mem_wdata !== 32'hA0 + 32'(i)) begin
            bad++;
            $display("FAIL drain%0d req=%0b addr=%h wd=%h exp=1,%h,%h", i,
                     bus.mem_req, bus.mem_addr, bus.mem_wdata,
                     30'h10 + 30'(i), 32'hA0 + 32'(i));
         end
         if (i == 0) begin
            total++;
            if (bus.st_ready !== 1'b0) begin
               bad++;
               $display("FAIL full_ack_rdy got=%0b exp=0", bus.st_ready);
            end
         end
         tick();
      end
      bus.mem_ack = 1'b0;
      total++;
      if (bus.empty !== 1'b1 || bus.mem_req !== 1'b0) begin
         bad++;
         $display("FAIL drain_empty empty=%0b req=%0b exp=1,0",
                  bus.empty, bus.mem_req);
      end
      for (int i = 0; i < 3; i++) begin
         bus.st_valid = 1'b1;
         bus.st_addr  = 30'h30 + 30'(i);
         bus.st_data  = 32'hB0 + 32'(i);
         tick();
      end
      bus.st_valid = 1'b0;
      bus.mem_ack  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         total++;
         if (bus.mem_addr !== 30'h30 + 30'(i) ||
             bus.mem_wdata !== 32'hB0 + 32'(i)) begin
            bad++;
            $display("FAIL wrap%0d addr=%h wd=%h exp=%h,%h", i,
                     bus.mem_addr, bus.mem_wdata,
                     30'h30 + 30'(i), 32'hB0 + 32'(i));
         end
         tick();
      end
      bus.mem_ack = 1'b0;
      total++;
      if (bus.empty !== 1'b1 || bus.count !== 3'd0) begin
         bad++;
         $display("FAIL wrap_empty empty=%0b cnt=%0d exp=1,0",
                  bus.empty, bus.count);
      end
   endtask

   task automatic test_push_pop;
      bus.mem_ack = 1'b0;
      for (int i = 0; i < 2; i++) begin
         bus.st_valid = 1'b1;
         bus.st_addr  = 30'h40 + 30'(i);
         bus.st_data  = 32'hC0 + 32'(i);
         tick();
      end
      bus.st_addr = 30'h42;
      bus.st_data = 32'hC2;
      bus.mem_ack = 1'b1;
      total++;
      if (bus.count !== 3'd2 || bus.mem_addr !== 30'h40) begin
         bad++;
         $display("FAIL pp_pre cnt=%0d addr=%h exp=2,40",
                  bus.count, bus.mem_addr);
      end
      tick();
      bus.st_valid = 1'b0;
      total++;
      if (bus.count !== 3'd2) begin
         bad++;
         $display("FAIL pp_count got=%0d exp=2", bus.count);
      end
      for (int i = 1; i < 3; i++) begin
         total++;
         if (bus.mem_addr !== 30'h40 + 30'(i) ||
             bus.mem_wdata !== 32'hC0 + 32'(i)) begin
            bad++;
            $display("FAIL pp_order%0d addr=%h wd=%h exp=%h,%h", i,
                     bus.mem_addr, bus.mem_wdata,
                     30'h40 + 30'(i), 32'hC0 + 32'(i));
         end
         tick();
      end
      bus.mem_ack = 1'b0;
      total++;
      if (bus.empty !== 1'b1) begin
         bad++;
         $display("FAIL pp_empty got=%0b exp=1", bus.empty);
      end
   endtask

   task automatic test_load;
      logic exp_hit;
      logic exp_stall;
      logic [31:0] exp_data;
`ifdef STORE_FWD_EN
      exp_hit = 1'b1;
      exp_stall = 1'b0;
      exp_data = 32'h22;
`else
      exp_hit = 1'b0;
      exp_stall = 1'b1;
      exp_data = 32'h0;
`endif
      bus.mem_ack  = 1'b0;
      bus.st_valid = 1'b1;
      bus.st_addr  = 30'h50;
      bus.st_data  = 32'h55;
      bus.ld_valid = 1'b1;
      bus.ld_addr  = 30'h50;
      total++;
      if (bus.ld_hit !== 1'b0 || bus.ld_stall !== 1'b0) begin
         bad++;
         $display("FAIL ld_samecyc hit=%0b st=%0b exp=0,0",
                  bus.ld_hit, bus.ld_stall);
      end
      bus.ld_valid = 1'b0;
      bus.mem_ack  = 1'b1;
      bus.st_valid = 1'b0;
      tick();
      bus.mem_ack  = 1'b0;
      bus.st_valid = 1'b1;
      bus.st_addr  = 30'h20;
      bus.st_data  = 32'h11;
      tick();
      bus.st_data  = 32'h22;
      tick();
      bus.st_valid = 1'b0;
      bus.ld_valid = 1'b1;
      bus.ld_addr  = 30'h20;
      #1;
      total++;
      if (bus.ld_hit !== exp_hit || bus.ld_stall !== exp_stall ||
          bus.ld_data !== exp_data) begin
         bad++;
         $display("FAIL ld_match hit=%0b st=%0b d=%h exp=%0b,%0b,%h",
                  bus.ld_hit, bus.ld_stall, bus.ld_data,
                  exp_hit, exp_stall, exp_data);
      end
      bus.ld_addr = 30'h21;
      #1;
      total++;
      if (bus.ld_hit !== 1'b0 || bus.ld_stall !== 1'b0 ||
          bus.ld_data !== 32'h0) begin
         bad++;
         $display("FAIL ld_miss hit=%0b st=%0b d=%h exp=0,0,0",
                  bus.ld_hit, bus.ld_stall, bus.ld_data);
      end
      bus.ld_valid = 1'b0;
      bus.ld_addr  = 30'h20;
      #1;
      total++;
      if (bus.ld_hit !== 1'b0 || bus.ld_stall !== 1'b0 ||
          bus.ld_data !== 32'h0) begin
         bad++;
         $display("FAIL ld_gate hit=%0b st=%0b d=%h exp=0,0,0",
                  bus.ld_hit, bus.ld_stall, bus.ld_data);
      end
      bus.ld_valid = 1'b1;
      bus.mem_ack  = 1'b1;
      for (int i = 0; i < 2; i++) begin
         #1;
         total++;
         if (bus.ld_hit !== exp_hit || bus.ld_stall !== exp_stall ||
             bus.ld_data !== exp_data) begin
            bad++;
            $display("FAIL ld_ack%0d hit=%0b st=%0b d=%h exp=%0b,%0b,%h", i,
                     bus.ld_hit, bus.ld_stall, bus.ld_data,
                     exp_hit, exp_stall, exp_data);
         end
         tick();
      end
      bus.mem_ack = 1'b0;
      total++;
      if (bus.ld_hit !== 1'b0 || bus.ld_stall !== 1'b0 ||
          bus.empty !== 1'b1) begin
         bad++;
         $display("FAIL ld_release hit=%0b st=%0b empty=%0b exp=0,0,1",
                  bus.ld_hit, bus.ld_stall, bus.empty);
      end
      bus.ld_valid = 1'b0;
   endtask

   task automatic test_async_reset;
      bus.mem_ack = 1'b0;
      for (int i = 0; i < 3; i++) begin
         bus.st_valid = 1'b1;
         bus.st_addr  = 30'h60 + 30'(i);
         bus.st_data  = 32'hD0 + 32'(i);
         tick();
      end
      bus.st_valid = 1'b0;
      total++;
      if (bus.mem_req !== 1'b1 || bus.count !== 3'd3) begin
         bad++;
         $display("FAIL ar_pre req=%0b cnt=%0d exp=1,3",
                  bus.mem_req, bus.count);
      end
      #1;
      rst = 1'b0;
      #1;
      total++;
      if (bus.mem_req !== 1'b0 || bus.count !== 3'd0 ||
          bus.empty !== 1'b1) begin
         bad++;
         $display("FAIL ar_now req=%0b cnt=%0d empty=%0b exp=0,0,1",
                  bus.mem_req, bus.count, bus.empty);
      end
      tick();
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         total++;
         if (bus.mem_req !== 1'b0 || bus.mem_addr !== 30'd0) begin
            bad++;
            $display("FAIL ar_stale%0d req=%0b addr=%h exp=0,0", i,
                     bus.mem_req, bus.mem_addr);
         end
      end
   endtask

   initial begin
      total = 0;
      bad = 0;
      rst = 1'b1;
      idle_inputs();
      test_reset();
      test_fill();
      test_drain();
      test_push_pop();
      test_load();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
